rv_wb: RTL and testbench
========================

Name: rv_wb

Overview:
- Write-back stage (Q104H) of the pipeline, directly downstream of the memory-access stage.
- Captures the Q103H write-back control.
- Formats load data returned by D_MEM: byte/half selection plus sign or zero extension.
- Selects the final write-back value and writes it into the integer register file, which this block owns.
- Serves the decode stage's two combinational read ports, with write-through bypass.

Parameters:
- NUM_REGS, 32, number of architectural integer registers. x0 is hardwired to zero.
- XLEN, 32, register and data width.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- ready_Q103H  input  1  Q103H instruction advances into Q104H this cycle
- rf_wr_en_Q103H  input  1  instruction writes rd
- rd_addr_Q103H  input  5  destination register
- sel_wb_Q103H  input  2  write-back source select: SEL_PC_PLUS4=0, SEL_ALU_OUT=1, SEL_DMEM_RD=2, 3=none
- load_funct3_Q103H  input  3  load type (RISC-V funct3)
- byte_offset_Q103H  input  2  alu_out[1:0] of the load address
- pre_wb_data_Q104H  input  XLEN  PC+4/ALU value, already registered by the memory-access stage
- dmem_rd_data_Q104H  input  XLEN  aligned 32-bit word returned by D_MEM, one cycle after the rd_en request
- rs1_addr_Q101H  input  5  read port 1 address
- rs2_addr_Q101H  input  5  read port 2 address
- rs1_data_Q101H  output  XLEN  read port 1 data (combinational)
- rs2_data_Q101H  output  XLEN  read port 2 data (combinational)
- wb_data_Q104H  output  XLEN  final write-back value (to forwarding unit)
- rf_wr_en_Q104H  output  1  Q104H write valid (to forwarding/hazard unit)
- rd_addr_Q104H  output  5  Q104H destination (to forwarding/hazard unit)

Behaviour:
- Q104H control registers (rf_wr_en, rd_addr, sel_wb, load_funct3, byte_offset) update every clock edge.
  - ready_Q103H=1: capture the Q103H inputs.
  - ready_Q103H=0: load a bubble, i.e. rf_wr_en_Q104H=0 and other fields 0. A stalled Q103H instruction therefore never writes twice.
- Reset (synchronous) clears:
  - all Q104H control registers, so rf_wr_en_Q104H=0 and rd_addr_Q104H=0;
  - all NUM_REGS registers to 0.
  - rs*_data outputs read 0 in the cycle after reset.
  - rst has priority over every other event in the same cycle, including a pending write.
- Load formatting (combinational in Q104H), with w=dmem_rd_data_Q104H and off=byte_offset_Q104H:
  - 000 LB: sign-extend w[8*off +: 8]
  - 100 LBU: zero-extend w[8*off +: 8]
  - 001 LH: sign-extend w[16*off[1] +: 16]; off[0] ignored
  - 101 LHU: zero-extend w[16*off[1] +: 16]; off[0] ignored
  - 010 LW: w; off ignored
  - any other funct3: w unmodified
- wb_data_Q104H:
  - formatted load when sel_wb_Q104H==SEL_DMEM_RD;
  - pre_wb_data_Q104H when sel is PC_PLUS4 or ALU_OUT;
  - 0 when sel==3.
- Register write:
  - On a clock edge with rf_wr_en_Q104H=1 and rd_addr_Q104H!=0, regs[rd_addr_Q104H] <= wb_data_Q104H.
  - Writes to x0 are discarded.
  - Latency: an instruction accepted at Q103H edge N writes on edge N+1.
- Read ports, per port:
  - addr==0 → 0;
  - else if rf_wr_en_Q104H and rd_addr_Q104H==addr → wb_data_Q104H (write-through bypass, same cycle);
  - else regs[addr].
  - Both ports may hit the bypass simultaneously.
  - Both ports may read the same register.
- No internal state besides the control registers and the register array.
- Only one write per cycle; no write/write conflicts.

Test Plan:
- Reset: assert rst one cycle after writing x5=0x1234 → next cycle rs1_addr=5 reads 0x00000000; rf_wr_en_Q104H=0.
- ALU write-back: rd=3, sel=ALU_OUT, pre_wb_data=0xDEADBEEF, ready=1.
  - In the Q104H cycle, rs1_addr=3 returns 0xDEADBEEF via bypass.
  - One cycle later, the same value comes from the array.
- Load formatting: dmem_rd_data=0x80FF7F01, rd=7, sel=DMEM.
  - LB off=1 → 0x0000007F
  - LB off=2 → 0xFFFFFFFF
  - LBU off=3 → 0x00000080
  - LH off=2 → 0xFFFF80FF
  - LHU off=0 → 0x00007F01
  - LW → 0x80FF7F01
- x0 protection: rd=0, rf_wr_en=1, wb value 0x55 → rs1/rs2 at addr 0 read 0 both in the write cycle and after.
- Stall: hold ready_Q103H=0 for 3 cycles behind a write to x9=0x11 → exactly one write; rf_wr_en_Q104H=0 in the stall cycles.
  - Then change pre_wb_data to 0x22 while still stalled → x9 stays 0x11.
- Dual-port bypass: write x12=0xA5A5A5A5 while rs1_addr=rs2_addr=12 → both outputs 0xA5A5A5A5 in the same cycle.

Source files
------------

// File: rtl/rv_wb_if.sv
// rv_wb_if: Q103H/Q104H write-back control, load data and register file read ports
interface rv_wb_if #(parameter int XLEN = 32);
  logic            ready_Q103H;
  logic            rf_wr_en_Q103H;
  logic [4:0]      rd_addr_Q103H;
  logic [1:0]      sel_wb_Q103H;
  logic [2:0]      load_funct3_Q103H;
  logic [1:0]      byte_offset_Q103H;
  logic [XLEN-1:0] pre_wb_data_Q104H;
  logic [XLEN-1:0] dmem_rd_data_Q104H;
  logic [4:0]      rs1_addr_Q101H;
  logic [4:0]      rs2_addr_Q101H;
  logic [XLEN-1:0] rs1_data_Q101H;
  logic [XLEN-1:0] rs2_data_Q101H;
  logic [XLEN-1:0] wb_data_Q104H;
  logic            rf_wr_en_Q104H;
  logic [4:0]      rd_addr_Q104H;
  modport master (
    output ready_Q103H, rf_wr_en_Q103H, rd_addr_Q103H, sel_wb_Q103H, load_funct3_Q103H,
           byte_offset_Q103H, pre_wb_data_Q104H, dmem_rd_data_Q104H, rs1_addr_Q101H, rs2_addr_Q101H,
    input  rs1_data_Q101H, rs2_data_Q101H, wb_data_Q104H, rf_wr_en_Q104H, rd_addr_Q104H
  );
  modport slave (
    input  ready_Q103H, rf_wr_en_Q103H, rd_addr_Q103H, sel_wb_Q103H, load_funct3_Q103H,
           byte_offset_Q103H, pre_wb_data_Q104H, dmem_rd_data_Q104H, rs1_addr_Q101H, rs2_addr_Q101H,
    output rs1_data_Q101H, rs2_data_Q101H, wb_data_Q104H, rf_wr_en_Q104H, rd_addr_Q104H
  );
endinterface

// File: rtl/rv_wb.sv
// rv_wb: Q104H write-back stage; load formatting, register file ownership, bypassed read ports
module rv_wb #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input logic   clk,
  input logic   rst,
  rv_wb_if.slave bus
);
  logic            r_wr_en;
  logic [4:0]      r_rd;
  logic [1:0]      r_sel;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_wb;
  assign w_byte = bus.dmem_rd_data_Q104H[{r_off, 3'b000} +: 8];
  assign w_half = bus.dmem_rd_data_Q104H[{r_off[1], 4'b0000} +: 16];
  always_comb begin
    w_load = r_f3 == 3'b000 ? {{(XLEN-8){w_byte[7]}}, w_byte} :
             r_f3 == 3'b100 ? {{(XLEN-8){1'b0}}, w_byte} :
             r_f3 == 3'b001 ? {{(XLEN-16){w_half[15]}}, w_half} :
             r_f3 == 3'b101 ? {{(XLEN-16){1'b0}}, w_half} :
                              bus.dmem_rd_data_Q104H;
    w_wb   = r_sel == 2'd2 ? w_load : r_sel == 2'd3 ? '0 : bus.pre_wb_data_Q104H;
  end
  assign bus.wb_data_Q104H  = w_wb;
  assign bus.rf_wr_en_Q104H = r_wr_en;
  assign bus.rd_addr_Q104H  = r_rd;
  // read ports see the Q104H write in the same cycle it lands
  assign bus.rs1_data_Q101H = bus.rs1_addr_Q101H == 5'd0 ? '0 :
                              (r_wr_en && r_rd == bus.rs1_addr_Q101H) ? w_wb : r_regs[bus.rs1_addr_Q101H];
  assign bus.rs2_data_Q101H = bus.rs2_addr_Q101H == 5'd0 ? '0 :
                              (r_wr_en && r_rd == bus.rs2_addr_Q101H) ? w_wb : r_regs[bus.rs2_addr_Q101H];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en <= 1'b0;
      r_rd    <= '0;
      r_sel   <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_en <= bus.ready_Q103H & bus.rf_wr_en_Q103H;
      r_rd    <= bus.ready_Q103H ? bus.rd_addr_Q103H : '0;
      r_sel   <= bus.ready_Q103H ? bus.sel_wb_Q103H : '0;
      r_f3    <= bus.ready_Q103H ? bus.load_funct3_Q103H : '0;
      r_off   <= bus.ready_Q103H ? bus.byte_offset_Q103H : '0;
      if (r_wr_en && r_rd != 5'd0) r_regs[r_rd] <= w_wb;
    end
  end
endmodule

// File: tb/tb_rv_wb.sv
// tb_rv_wb: random and directed stimulus for rv_wb against a register-file reference model
module tb_rv_wb;
  logic clk = 1'b0;
  logic rst;
  rv_wb_if #(.XLEN(32)) bus ();
  rv_wb #(.NUM_REGS(32), .XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    bit       we;
    bit [4:0] rd;
    bit [1:0] sel;
    bit [2:0] f3;
    bit [1:0] off;
  } stg_t;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mdl [32];
  stg_t        stg;
  stg_t        nxt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] fmt(input stg_t s, input logic [31:0] pre, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * s.off)) & 32'hFF;
    h = (w >> (16 * (s.off / 2))) & 32'hFFFF;
    if (s.sel == 3) return 0;
    if (s.sel != 2) return pre;
    case (s.f3)
      3'd0: return b >= 128 ? b + 32'hFFFFFF00 : b;
      3'd4: return b;
      3'd1: return h >= 32768 ? h + 32'hFFFF0000 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] rd_port(input logic [4:0] a);
    if (a == 0) return 0;
    if (stg.we && stg.rd == a) return fmt(stg, bus.pre_wb_data_Q104H, bus.dmem_rd_data_Q104H);
    return mdl[a];
  endfunction

  task automatic drive(input bit rdy, input bit we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [1:0] off, input logic [31:0] pre,
                       input logic [31:0] dm, input logic [4:0] a1, input logic [4:0] a2);
    bus.ready_Q103H = rdy;
    bus.rf_wr_en_Q103H = we;
    bus.rd_addr_Q103H = rd;
    bus.sel_wb_Q103H = sel;
    bus.load_funct3_Q103H = f3;
    bus.byte_offset_Q103H = off;
    bus.pre_wb_data_Q104H = pre;
    bus.dmem_rd_data_Q104H = dm;
    bus.rs1_addr_Q101H = a1;
    bus.rs2_addr_Q101H = a2;
    nxt = rdy ? '{we, rd, sel, f3, off} : '{0, 0, 0, 0, 0};
  endtask

  // compare against the model, then advance the model across one clock edge
  task automatic tick();
    logic [31:0] wb;
    #1;
    wb = fmt(stg, bus.pre_wb_data_Q104H, bus.dmem_rd_data_Q104H);
    check("wb_data", bus.wb_data_Q104H, wb);
    check("wr_en", 32'(bus.rf_wr_en_Q104H), 32'(stg.we));
    check("rd_addr", 32'(bus.rd_addr_Q104H), 32'(stg.rd));
    check("rs1", bus.rs1_data_Q101H, rd_port(bus.rs1_addr_Q101H));
    check("rs2", bus.rs2_data_Q101H, rd_port(bus.rs2_addr_Q101H));
    @(posedge clk);
    if (rst) begin
      foreach (mdl[i]) mdl[i] = 0;
      stg = '{0, 0, 0, 0, 0};
    end else begin
      if (stg.we && stg.rd != 0) mdl[stg.rd] = wb;
      stg = nxt;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    foreach (mdl[i]) mdl[i] = 0;
    stg = '{0, 0, 0, 0, 0};
    #1;
    rst = 1'b0;
  endtask

  task automatic load_test(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] exp);
    drive(1, 1, 7, 2, f3, off, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h1111_2222, 32'h80FF7F01, 7, 0);
    #1;
    check(tag, bus.wb_data_Q104H, exp);
    tick();
    check({tag, "_rf"}, bus.rs1_data_Q101H, exp);
  endtask

  initial begin
    rst = 1'b0;
    do_reset();
    check("rst_wr_en", 32'(bus.rf_wr_en_Q104H), 0);
    drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h1234, 0, 5, 0);
    tick();
    check("x5_written", bus.rs1_data_Q101H, 32'h1234);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    check("rst_x5", bus.rs1_data_Q101H, 0);
    check("rst_wr_en2", 32'(bus.rf_wr_en_Q104H), 0);
    tick();

    drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 3, 0);
    #1;
    check("alu_bypass", bus.rs1_data_Q101H, 32'hDEADBEEF);
    tick();
    check("alu_array", bus.rs1_data_Q101H, 32'hDEADBEEF);

    load_test("lb1", 3'b000, 2'd1, 32'h0000007F);
    load_test("lb2", 3'b000, 2'd2, 32'hFFFFFFFF);
    load_test("lbu3", 3'b100, 2'd3, 32'h00000080);
    load_test("lh2", 3'b001, 2'd2, 32'hFFFF80FF);
    load_test("lhu0", 3'b101, 2'd0, 32'h00007F01);
    load_test("lw", 3'b010, 2'd0, 32'h80FF7F01);

    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0);
    #1;
    check("x0_rs1_wcyc", bus.rs1_data_Q101H, 0);
    check("x0_rs2_wcyc", bus.rs2_data_Q101H, 0);
    tick();
    check("x0_rs1_after", bus.rs1_data_Q101H, 0);

    drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 9, 1, 0, 0, 32'h11, 0, 9, 0);
      tick();
      check("stall_wr_en", 32'(bus.rf_wr_en_Q104H), 0);
    end
    drive(0, 1, 9, 1, 0, 0, 32'h22, 0, 9, 0);
    tick();
    check("stall_x9", bus.rs1_data_Q101H, 32'h11);

    drive(1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 12, 12);
    #1;
    check("dual_rs1", bus.rs1_data_Q101H, 32'hA5A5A5A5);
    check("dual_rs2", bus.rs2_data_Q101H, 32'hA5A5A5A5);
    tick();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
